dual_issue_scheduler: RTL and testbench

Decode-stage issue controller for the two-lane in-order pipeline. Each cycle it decides whether the decoded instruction pair issues together, issues slot 1 then slot 2 on consecutive cycles, or stalls. It handles the hazards that EX/MA forwarding cannot resolve: load-use hazards, intra-pair RAW/WAW conflicts, and the single shared multi-cycle multiply/divide unit (MDU). Its outputs drive the ID hold, the EX bubble insertion and the MDU start strobe.

---
 rtl/dual_issue_scheduler.sv | 150 +++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// Decode-stage issue controller for the two-lane in-order pipeline.
// Decides dual issue, split issue (lane 1 then lane 2) or stall, covering
// load-use, intra-pair RAW/WAW and shared multiply/divide unit hazards.
//
// state  | meaning
// -------+-----------------------------------------------------------
// PAIR   | both ID instructions pending; evaluate the whole pair
// SECOND | lane 1 already issued; only lane 2 remains in ID
module dual_issue_scheduler #(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       id_valid,
  input  logic [4:0] id_rs11,
  input  logic [4:0] id_rs12,
  input  logic [4:0] id_rs21,
  input  logic [4:0] id_rs22,
  input  logic [4:0] id_rd1,
  input  logic [4:0] id_rd2,
  input  logic       id_we1,
  input  logic       id_we2,
  input  logic       id_mdu1,
  input  logic       id_mdu2,
  input  logic [4:0] ex_rd1,
  input  logic [4:0] ex_rd2,
  input  logic       ex_load1,
  input  logic       ex_load2,
  output logic       issue1,
  output logic       issue2,
  output logic       id_stall,
  output logic       ex_bubble,
  output logic       mdu_start,
  output logic       mdu_busy
);

  typedef enum logic {
    PAIR   = 1'b0,
    SECOND = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] mdu_cnt_q, mdu_cnt_d;
  logic [4:0] mdu_tag_q, mdu_tag_d;

  logic busy_int;
  logic lu1, lu2, mdu_hz1, mdu_hz2, hz1, hz2, split;
  logic [4:0] tag_new;

  // A writer to x0 or a disabled writer never creates a dependency.
  function automatic logic src_match(input logic [4:0] src,
                                     input logic [4:0] rd,
                                     input logic       we);
    return we && (rd != 5'd0) && (src == rd);
  endfunction

  // Per-lane hazard detection and the pair split decision.
  always_comb begin
    busy_int = (mdu_cnt_q != 4'd0);
    lu1 = src_match(id_rs11, ex_rd1, ex_load1) | src_match(id_rs11, ex_rd2, ex_load2) |
          src_match(id_rs12, ex_rd1, ex_load1) | src_match(id_rs12, ex_rd2, ex_load2);
    lu2 = src_match(id_rs21, ex_rd1, ex_load1) | src_match(id_rs21, ex_rd2, ex_load2) |
          src_match(id_rs22, ex_rd1, ex_load1) | src_match(id_rs22, ex_rd2, ex_load2);
    mdu_hz1 = busy_int && (id_mdu1 || ((mdu_tag_q != 5'd0) &&
              ((id_rs11 == mdu_tag_q) || (id_rs12 == mdu_tag_q))));
    mdu_hz2 = busy_int && (id_mdu2 || ((mdu_tag_q != 5'd0) &&
              ((id_rs21 == mdu_tag_q) || (id_rs22 == mdu_tag_q))));
    hz1 = lu1 | mdu_hz1;
    hz2 = lu2 | mdu_hz2;
    split = src_match(id_rs21, id_rd1, id_we1) |
            src_match(id_rs22, id_rd1, id_we1) |
            (id_we1 && id_we2 && (id_rd1 != 5'd0) && (id_rd1 == id_rd2)) |
            (id_mdu1 && id_mdu2) |
            hz2;
  end

  // Issue/stall decision and next-state; flush overrides every hazard.
  always_comb begin
    state_d   = state_q;
    issue1    = 1'b0;
    issue2    = 1'b0;
    id_stall  = 1'b0;
    ex_bubble = 1'b0;
    if (rst) begin
      state_d = PAIR;
    end else if (flush) begin
      ex_bubble = 1'b1;
      state_d   = PAIR;
    end else begin
      case (state_q)
        PAIR: begin
          if (id_valid) begin
            if (hz1) begin
              id_stall  = 1'b1;
              ex_bubble = 1'b1;
            end else if (split) begin
              issue1   = 1'b1;
              id_stall = 1'b1;
              state_d  = SECOND;
            end else begin
              issue1 = 1'b1;
              issue2 = 1'b1;
            end
          end
        end
        SECOND: begin
          if (!id_valid) begin
            state_d = PAIR;
          end else if (hz2) begin
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
          end else begin
            issue2  = 1'b1;
            state_d = PAIR;
          end
        end
        default: state_d = PAIR;
      endcase
    end
  end

  // MDU occupancy: a new start reloads the counter even if it is expiring.
  always_comb begin
    mdu_start = (issue1 & id_mdu1) | (issue2 & id_mdu2);
    if (issue1 && id_mdu1) tag_new = id_we1 ? id_rd1 : 5'd0;
    else                   tag_new = id_we2 ? id_rd2 : 5'd0;
    if (mdu_start)     mdu_cnt_d = 4'(MDU_LAT);
    else if (busy_int) mdu_cnt_d = mdu_cnt_q - 4'd1;
    else               mdu_cnt_d = 4'd0;
    if (mdu_start)                            mdu_tag_d = tag_new;
    else if (flush || (mdu_cnt_d == 4'd0))    mdu_tag_d = 5'd0;
    else                                      mdu_tag_d = mdu_tag_q;
    mdu_busy = busy_int & ~rst;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PAIR;
      mdu_cnt_q <= 4'd0;
      mdu_tag_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      mdu_tag_q <= mdu_tag_d;
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler with MDU_LAT=4.
// Observed vector: {issue1, issue2, id_stall, ex_bubble, mdu_start, mdu_busy}.
module tb_dual_issue_scheduler;

  logic clk = 1'b0;
  logic rst, flush, id_valid;
  logic [4:0] id_rs11, id_rs12, id_rs21, id_rs22, id_rd1, id_rd2, ex_rd1, ex_rd2;
  logic id_we1, id_we2, id_mdu1, id_mdu2, ex_load1, ex_load2;
  logic issue1, issue2, id_stall, ex_bubble, mdu_start, mdu_busy;
  logic [5:0] obs;
  int checks = 0;
  int errors = 0;

  assign obs = {issue1, issue2, id_stall, ex_bubble, mdu_start, mdu_busy};

  always #5 clk = ~clk;

  dual_issue_scheduler #(.MDU_LAT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs11(id_rs11), .id_rs12(id_rs12), .id_rs21(id_rs21), .id_rs22(id_rs22),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_we1(id_we1), .id_we2(id_we2),
    .id_mdu1(id_mdu1), .id_mdu2(id_mdu2), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_load1(ex_load1), .ex_load2(ex_load2),
    .issue1(issue1), .issue2(issue2), .id_stall(id_stall), .ex_bubble(ex_bubble),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy)
  );

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    flush = 0; id_valid = 0;
    id_rs11 = 0; id_rs12 = 0; id_rs21 = 0; id_rs22 = 0;
    id_rd1 = 0; id_rd2 = 0; id_we1 = 0; id_we2 = 0;
    id_mdu1 = 0; id_mdu2 = 0;
    ex_rd1 = 0; ex_rd2 = 0; ex_load1 = 0; ex_load2 = 0;
  endtask

  // Independent pair: rs11=1, rs21=2, rd1=5, rd2=6.
  task automatic indep_pair;
    clear_inputs();
    id_valid = 1; id_rs11 = 1; id_rs12 = 2; id_rs21 = 2; id_rs22 = 1;
    id_rd1 = 5; id_rd2 = 6; id_we1 = 1; id_we2 = 1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    id_valid = 1; id_mdu1 = 1; id_rd1 = 3; id_we1 = 1; id_rs21 = 3;
    nxt(); nxt(); #2;
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL reset_outputs: got %b exp %b", obs, 6'b000000); end
    nxt();
    rst = 0;
    clear_inputs();
    #2;
    checks++;
    if (obs !== 6'b000000) begin errors++; $display("FAIL idle_after_reset: got %b exp %b", obs, 6'b000000); end
    nxt();
  endtask

  task automatic test_dual;
    indep_pair(); #2;
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL dual_issue: got %b exp %b", obs, 6'b110000); end
    nxt();
    indep_pair(); id_rd1 = 0; id_rs21 = 0; ex_rd1 = 0; ex_load1 = 1; id_rs11 = 0; #2;
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL x0_no_hazard: got %b exp %b", obs, 6'b110000); end
    nxt();
    indep_pair(); id_rs21 = 5; id_we1 = 0; #2;
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL raw_we_off: got %b exp %b", obs, 6'b110000); end
    nxt();
  endtask

  task automatic test_raw;
    indep_pair(); id_rs21 = 5; #2;
    checks++;
    if (obs !== 6'b101000) begin errors++; $display("FAIL raw_split_c0: got %b exp %b", obs, 6'b101000); end
    nxt(); #2;
    checks++;
    if (obs !== 6'b010000) begin errors++; $display("FAIL raw_split_c1: got %b exp %b", obs, 6'b010000); end
    nxt();
    indep_pair(); #2;
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL raw_back_to_pair: got %b exp %b", obs, 6'b110000); end
    nxt();
    indep_pair(); id_rd1 = 8; id_rd2 = 8; #2;
    checks++;
    if (obs !== 6'b101000) begin errors++; $display("FAIL waw_split_c0: got %b exp %b", obs, 6'b101000); end
    nxt(); #2;
    checks++;
    if (obs !== 6'b010000) begin errors++; $display("FAIL waw_split_c1: got %b exp %b", obs, 6'b010000); end
    nxt();
  endtask

  task automatic test_load_use;
    indep_pair(); id_rs12 = 7; ex_rd2 = 7; ex_load2 = 1; #2;
    checks++;
    if (obs !== 6'b001100) begin errors++; $display("FAIL lu_stall: got %b exp %b", obs, 6'b001100); end
    nxt();
    ex_load2 = 0; ex_rd2 = 0; #2;
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL lu_after_stall: got %b exp %b", obs, 6'b110000); end
    nxt();
  endtask

  task automatic test_split_load;
    indep_pair(); id_rd1 = 9; id_rs22 = 9; #2;
    checks++;
    if (obs !== 6'b101000) begin errors++; $display("FAIL sl_c0: got %b exp %b", obs, 6'b101000); end
    nxt();
    ex_rd1 = 9; ex_load1 = 1; #2;
    checks++;
    if (obs !== 6'b001100) begin errors++; $display("FAIL sl_c1_stall: got %b exp %b", obs, 6'b001100); end
    nxt();
    ex_load1 = 0; ex_rd1 = 0; #2;
    checks++;
    if (obs !== 6'b010000) begin errors++; $display("FAIL sl_c2_issue2: got %b exp %b", obs, 6'b010000); end
    nxt();
    indep_pair(); #2;
    checks++;
    if (obs !== 6'b110000) begin errors++; $display("FAIL sl_c3_pair: got %b exp %b", obs, 6'b110000); end
    nxt();
  endtask

  task automatic drain(input string nm);
    logic [5:0] exp;
    clear_inputs();
    for (int i = 1; i <= 5; i++) begin
      #2;
      exp = (i < 5) ? 6'b000001 : 6'b000000;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL %s_drain%0d: got %b exp %b", nm, i, obs, exp); end
      nxt();
    end
  endtask

  task automatic test_mdu;
    logic [5:0] exp;
    indep_pair(); id_mdu1 = 1; id_rd1 = 3; #2;
    checks++;
    if (obs !== 6'b110010) begin errors++; $display("FAIL mdu_start_T: got %b exp %b", obs, 6'b110010); end
    nxt();
    for (int i = 1; i <= 5; i++) begin
      indep_pair(); id_rs11 = 3; #2;
      exp = (i < 5) ? 6'b001101 : 6'b110000;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mdu_dep_T+%0d: got %b exp %b", i, obs, exp); end
      nxt();
    end
    indep_pair(); id_rd1 = 10; id_rd2 = 11; id_mdu1 = 1; id_mdu2 = 1; #2;
    checks++;
    if (obs !== 6'b101010) begin errors++; $display("FAIL mdu_pair_split: got %b exp %b", obs, 6'b101010); end
    nxt();
    for (int i = 1; i <= 5; i++) begin
      #2;
      exp = (i < 5) ? 6'b001101 : 6'b010010;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mdu_second_T+%0d: got %b exp %b", i, obs, exp); end
      nxt();
    end
    drain("mdu");
  endtask

  task automatic test_flush;
    indep_pair(); id_mdu1 = 1; id_rd1 = 4; id_rs21 = 4; #2;
    checks++;
    if (obs !== 6'b101010) begin errors++; $display("FAIL fl_split: got %b exp %b", obs, 6'b101010); end
    nxt();
    flush = 1; #2;
    checks++;
    if (obs !== 6'b000101) begin errors++; $display("FAIL fl_flush: got %b exp %b", obs, 6'b000101); end
    nxt();
    indep_pair(); id_rs11 = 4; id_rs21 = 4; #2;
    checks++;
    if (obs !== 6'b110001) begin errors++; $display("FAIL fl_tag_cleared: got %b exp %b", obs, 6'b110001); end
    nxt();
    indep_pair(); id_mdu1 = 1; id_rd1 = 12; #2;
    checks++;
    if (obs !== 6'b001101) begin errors++; $display("FAIL fl_busy_c2: got %b exp %b", obs, 6'b001101); end
    nxt(); #2;
    checks++;
    if (obs !== 6'b001101) begin errors++; $display("FAIL fl_busy_c1: got %b exp %b", obs, 6'b001101); end
    nxt(); #2;
    checks++;
    if (obs !== 6'b110010) begin errors++; $display("FAIL fl_mdu_restart: got %b exp %b", obs, 6'b110010); end
    nxt();
    drain("fl");
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    test_reset();
    test_dual();
    test_raw();
    test_load_use();
    test_split_load();
    test_mdu();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
